// File: rtl/motor_pwm.sv
// H-bridge PWM driver: period counter, once-per-period command sample, dead-time on reversal.
// Gates are registered one cycle behind the counter compare.
module motor_pwm #(
   parameter int PERIOD      = 1000,
   parameter int MAX_DUTY    = 950,
   parameter int DEAD_CYCLES = 50
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic signed [15:0] Motor,
   output logic               pwm_a,
   output logic               pwm_b,
   output logic               dir,
   output logic               sat,
   output logic               period_tick
);

   typedef enum logic [1:0] {ST_STOP, ST_FWD, ST_REV, ST_DEAD} state_t;

   localparam logic [15:0] CNT_LAST  = 16'(PERIOD - 1);
   localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);
   localparam logic [16:0] MAX_D17   = 17'(MAX_DUTY);

   logic [15:0] cnt_q, cnt_d;
   logic [15:0] dead_q, dead_d;
   logic [15:0] duty_q, duty_d;
   state_t      state_q, state_d;
   state_t      tgt_q, tgt_d;
   logic        pwm_a_q, pwm_a_d;
   logic        pwm_b_q, pwm_b_d;
   logic        dir_q, dir_d;
   logic        sat_q, sat_d;

   logic        sample;
   logic [16:0] mot_ext;
   logic [16:0] mag;
   logic        clip;
   logic [15:0] duty_new;
   state_t      sign_tgt;

   // Magnitude in 17 bits so that -32768 maps to +32768 without wrapping.
   always_comb begin
      sample   = (cnt_q == CNT_LAST);
      mot_ext  = {Motor[15], Motor};
      mag      = Motor[15] ? (~mot_ext + 17'd1) : mot_ext;
      clip     = (mag > MAX_D17);
      duty_new = clip ? MAX_D17[15:0] : mag[15:0];
      if (Motor == 16'sd0) begin
         sign_tgt = ST_STOP;
      end else if (Motor[15]) begin
         sign_tgt = ST_REV;
      end else begin
         sign_tgt = ST_FWD;
      end
   end

   always_comb begin
      cnt_d   = sample ? 16'd0 : 16'(cnt_q + 16'd1);
      state_d = state_q;
      tgt_d   = tgt_q;
      dead_d  = dead_q;
      duty_d  = duty_q;
      sat_d   = sat_q;
      dir_d   = dir_q;

      if (!en) begin
         state_d = ST_STOP;
         tgt_d   = ST_STOP;
         dead_d  = 16'd0;
         duty_d  = 16'd0;
      end else begin
         if (state_q == ST_DEAD) begin
            dead_d = 16'(dead_q + 16'd1);
         end
         if (sample) begin
            duty_d = duty_new;
            sat_d  = clip;
            tgt_d  = sign_tgt;
         end
         case (state_q)
            ST_STOP: begin
               if (sample) begin
                  state_d = sign_tgt;
               end
            end
            ST_FWD, ST_REV: begin
               if (sample) begin
                  if (sign_tgt == ST_STOP) begin
                     state_d = ST_STOP;
                  end else if (sign_tgt != state_q) begin
                     state_d = ST_DEAD;
                     dead_d  = 16'd0;
                  end
               end
            end
            ST_DEAD: begin
               // A new sample retargets the reversal but keeps the dead interval running.
               if (sample && sign_tgt == ST_STOP) begin
                  state_d = ST_STOP;
               end else if (dead_q == DEAD_LAST) begin
                  state_d = tgt_d;
               end
            end
            default: state_d = ST_STOP;
         endcase
      end

      if (state_d == ST_FWD) begin
         dir_d = 1'b0;
      end else if (state_d == ST_REV) begin
         dir_d = 1'b1;
      end

      pwm_a_d = en && (state_q == ST_FWD) && (cnt_q < duty_q);
      pwm_b_d = en && (state_q == ST_REV) && (cnt_q < duty_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= 16'd0;
         dead_q  <= 16'd0;
         duty_q  <= 16'd0;
         state_q <= ST_STOP;
         tgt_q   <= ST_STOP;
         pwm_a_q <= 1'b0;
         pwm_b_q <= 1'b0;
         dir_q   <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         dead_q  <= dead_d;
         duty_q  <= duty_d;
         state_q <= state_d;
         tgt_q   <= tgt_d;
         pwm_a_q <= pwm_a_d;
         pwm_b_q <= pwm_b_d;
         dir_q   <= dir_d;
         sat_q   <= sat_d;
      end
   end

   assign pwm_a       = pwm_a_q;
   assign pwm_b       = pwm_b_q;
   assign dir         = dir_q;
   assign sat         = sat_q;
   assign period_tick = (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_motor_pwm.sv
// Bench for motor_pwm: per-cycle comparison against a drive/dead-time model plus per-period pulse counts.
module tb_motor_pwm;

   localparam int P    = 1000;
   localparam int MAXD = 950;
   localparam int DC   = 50;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic signed [15:0] motor;
   logic               pwm_a, pwm_b, dir, sat, period_tick;

   int checks = 0;
   int errors = 0;

   motor_pwm #(.PERIOD(P), .MAX_DUTY(MAXD), .DEAD_CYCLES(DC)) dut (
      .clk(clk), .rst(rst), .en(en), .Motor(motor),
      .pwm_a(pwm_a), .pwm_b(pwm_b), .dir(dir), .sat(sat), .period_tick(period_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: drive is the target direction (-1/0/+1); dead is the number of
   // both-off cycles still owed before that direction may be driven.
   typedef struct {
      int cnt; int duty; int drive; int dead; int dir; int sat; int a; int b;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t step(mstate_t s, logic e, logic signed [15:0] mo);
      mstate_t n = s;
      int mag, sg;
      bit in_dead = (s.dead > 0);
      n.a = (e && s.drive == 1  && s.dead == 0 && s.cnt < s.duty) ? 1 : 0;
      n.b = (e && s.drive == -1 && s.dead == 0 && s.cnt < s.duty) ? 1 : 0;
      if (!e) begin
         n.drive = 0; n.dead = 0; n.duty = 0;
      end else begin
         if (in_dead) n.dead = s.dead - 1;
         if (s.cnt == P - 1) begin
            mag    = (mo < 0) ? -int'(mo) : int'(mo);
            sg     = (mo < 0) ? -1 : ((mo > 0) ? 1 : 0);
            n.duty = (mag > MAXD) ? MAXD : mag;
            n.sat  = (mag > MAXD) ? 1 : 0;
            if (sg == 0) begin
               n.drive = 0; n.dead = 0;
            end else if (in_dead || s.drive == 0 || s.drive == sg) begin
               n.drive = sg;
            end else begin
               n.drive = sg; n.dead = DC;
            end
         end
         if (n.dead == 0 && n.drive != 0) n.dir = (n.drive < 0) ? 1 : 0;
      end
      n.cnt = (s.cnt + 1) % P;
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= '{0, 0, 0, 0, 0, 0, 0, 0};
      else     m <= step(m, en, motor);
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("pwm_a", int'(pwm_a), m.a);
         chk("pwm_b", int'(pwm_b), m.b);
         chk("dir", int'(dir), m.dir);
         chk("sat", int'(sat), m.sat);
         chk("period_tick", int'(period_tick), (m.cnt == P - 1) ? 1 : 0);
         chk("gates_exclusive", int'(pwm_a & pwm_b), 0);
      end
   end

   // Counts gate-high cycles over one full period starting at cnt = 0.
   // Returns sitting on the negedge of the next period_tick.
   task automatic measure(output int na, output int nb, input int chg_at,
                          input logic signed [15:0] chg_val, input int en_off_at);
      int w = 0;
      na = 0; nb = 0;
      while (!period_tick && w < 2 * P) begin
         @(negedge clk);
         w++;
      end
      if (!period_tick) chk("tick_timeout", w, 0);
      for (int k = 0; k < P; k++) begin
         @(negedge clk);
         if (pwm_a) na++;
         if (pwm_b) nb++;
         if (k == chg_at) motor = chg_val;
         if (k == en_off_at) en = 1'b0;
      end
   endtask

   task automatic expect_period(input string name, input int ea, input int eb);
      int na, nb;
      measure(na, nb, -1, 16'sd0, -1);
      chk({name, "_a_count"}, na, ea);
      chk({name, "_b_count"}, nb, eb);
   endtask

   initial begin
      int na, nb, n;
      rst = 1'b1; en = 1'b0; motor = 16'sd0;
      repeat (3) @(negedge clk);
      chk("rst_pwm_a", int'(pwm_a), 0);
      chk("rst_pwm_b", int'(pwm_b), 0);
      chk("rst_dir", int'(dir), 0);
      chk("rst_sat", int'(sat), 0);
      chk("rst_tick", int'(period_tick), 0);
      rst = 1'b0;

      en = 1'b1; motor = 16'sd300;
      expect_period("fwd300", 300, 0);
      chk("fwd300_dir", int'(dir), 0);
      chk("fwd300_sat", int'(sat), 0);

      motor = -16'sd32768;
      expect_period("rev_min_dead", 0, MAXD - DC);
      expect_period("rev_min", 0, MAXD);
      chk("rev_min_dir", int'(dir), 1);
      chk("rev_min_sat", int'(sat), 1);

      motor = 16'sd1200;
      expect_period("fwd1200_dead", MAXD - DC, 0);
      expect_period("fwd1200", MAXD, 0);
      chk("fwd1200_sat", int'(sat), 1);
      chk("fwd1200_dir", int'(dir), 0);

      motor = 16'sd300;
      expect_period("fwd300b", 300, 0);
      motor = -16'sd300;
      expect_period("rev300_dead", 0, 300 - DC);
      expect_period("rev300", 0, 300);

      motor = 16'sd300;
      expect_period("fwd300_dead", 300 - DC, 0);
      motor = 16'sd0;
      expect_period("stop", 0, 0);
      chk("stop_dir_hold", int'(dir), 0);
      motor = 16'sd200;
      expect_period("fwd200_nodead", 200, 0);

      measure(na, nb, 500, 16'sd700, -1);
      chk("midchange_a_count", na, 200);
      expect_period("fwd700", 700, 0);
      measure(na, nb, -1, 16'sd0, 100);
      chk("en_off_a_count", na, 100);
      chk("en_off_pwm_a", int'(pwm_a), 0);
      en = 1'b1; motor = 16'sd200;
      expect_period("en_resume", 200, 0);

      repeat (21) @(negedge clk);
      chk("pre_rst_pwm_a", int'(pwm_a), 1);
      rst = 1'b1;
      #1;
      chk("async_rst_pwm_a", int'(pwm_a), 0);
      chk("async_rst_dir", int'(dir), 0);
      chk("async_rst_tick", int'(period_tick), 0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_tick && n < 2 * P);
      chk("rst_restart_cycles", n, P - 1);
      expect_period("post_rst", 200, 0);

      for (int p = 0; p < 25; p++) begin
         case ($urandom_range(0, 5))
            0: motor = 16'sd0;
            1: motor = -16'sd32768;
            2: motor = 16'sd32767;
            3: motor = 16'($signed($urandom_range(0, 2000)) - 1000);
            4: motor = 16'($urandom);
            default: motor = 16'(MAXD - 1 + $urandom_range(0, 2));
         endcase
         en = ($urandom_range(0, 7) != 0);
         measure(na, nb, $urandom_range(0, P - 1), 16'($urandom),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, P - 1) : -1);
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/motor_pwm.md
MOTOR_PWM -- requirements
Module: motor_pwm

Interface
REQ-001 Parameter PERIOD, default 1000, PWM period in clk cycles (2..65535).
REQ-002 Parameter MAX_DUTY, default 950, duty saturation limit in counts (MAX_DUTY < PERIOD).
REQ-003 Parameter DEAD_CYCLES, default 50, both-off interval on direction reversal (1..PERIOD-1).
REQ-004 clk  input  1  system clock, rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  drive enable; 0 forces outputs off.
REQ-007 Motor  input  16  signed two's-complement drive command from the PD control stage (balance minus position).
REQ-008 pwm_a  output  1  forward H-bridge gate, registered.
REQ-009 pwm_b  output  1  reverse H-bridge gate, registered.
REQ-010 dir  output  1  current drive direction, 1 = reverse, registered.
REQ-011 sat  output  1  last sampled command was clipped to MAX_DUTY, registered.
REQ-012 period_tick  output  1  one-cycle pulse when counter = PERIOD-1.

Function
REQ-013 16-bit counter cnt SHALL count 0..PERIOD-1 and wrap to 0; it SHALL run regardless of en.
REQ-014 Motor SHALL be sampled only on the clock edge where cnt = PERIOD-1; it is ignored at all other cycles.
REQ-015 Sampled magnitude |Motor| SHALL be computed in 17 bits (-32768 -> 32768); duty_reg = min(|Motor|, MAX_DUTY); sat = 1 iff |Motor| > MAX_DUTY.
REQ-016 Sampled sign SHALL be the target direction: negative -> REV, positive -> FWD, zero -> STOP.
REQ-017 State machine states: STOP, FWD, REV, DEAD.
REQ-018 At sample: STOP -> FWD/REV directly, no dead time; FWD/REV with same sign stay; FWD/REV with zero -> STOP; FWD<->REV sign change -> DEAD with dead counter cleared, target latched.
REQ-019 In DEAD: dead counter increments each cycle; at DEAD_CYCLES elapsed -> target state; a sample during DEAD updates target, with zero -> STOP immediately, and does not restart the dead counter.
REQ-020 pwm_a SHALL be 1 in the cycle after any cycle with state = FWD and cnt < duty_reg; pwm_b likewise for REV; both SHALL be 0 in STOP and DEAD.
REQ-021 pwm_a and pwm_b SHALL never be 1 in the same cycle.
REQ-022 dir SHALL update on entry to FWD (0) or REV (1) and hold through STOP and DEAD.
REQ-023 Duty changes SHALL take effect only from cnt = 0; no mid-period glitch.
REQ-024 en = 0 SHALL force state STOP, duty_reg = 0, pwm_a = pwm_b = 0 from the next edge; after en returns to 1, driving resumes at the next sample.
REQ-025 duty_reg = 0 in FWD/REV SHALL give constant-low output; duty_reg = MAX_DUTY SHALL give MAX_DUTY high cycles per period.

Reset
REQ-026 rst = 1 SHALL asynchronously set cnt = 0, dead counter = 0, duty_reg = 0, state STOP, target STOP, pwm_a = pwm_b = dir = sat = period_tick = 0.
REQ-027 Reset asserted mid-period or mid-DEAD SHALL drop the gates immediately; after release cnt restarts at 0 and the first sample occurs at cnt = PERIOD-1.

Verification
REQ-028 Defaults, en = 1, Motor = 300 held -> from second period pwm_a high exactly 300 cycles per 1000, pwm_b = 0, dir = 0, sat = 0.
REQ-029 Motor = -32768 -> pwm_b high 950 cycles per period, dir = 1, sat = 1; Motor = 1200 -> pwm_a 950 cycles, sat = 1.
REQ-030 Motor switches 300 -> -300 -> both gates low for 50 cycles after the sample, then pwm_b high for cycles 50..299 of that period, full 300 cycles in the following period.
REQ-031 Motor = 0 sampled while FWD -> STOP with no dead interval, gates low; next sample 200 -> pwm_a 200 cycles immediately.
REQ-032 Motor changed at cnt = 500 -> no change to the current period's pulse width; en dropped at cnt = 100 -> gates low from the next edge.
REQ-033 rst pulsed at cnt = 20 during a pwm_a high phase -> pwm_a = 0 asynchronously, all outputs at reset values, clean period restart after release.
